// File: rtl/bcd_serial_adder_if.sv
// Handshake and operand/result bundle for the digit-serial BCD adder.
// The master drives the request and operands; the slave returns status and result.
interface bcd_serial_adder_if #(
    parameter int NDIG = 4
);
    logic                start;
    logic [4*NDIG-1:0]   a;
    logic [4*NDIG-1:0]   b;
    logic                cin;
    logic                busy;
    logic                done;
    logic [4*NDIG-1:0]   sum;
    logic                cout;
    logic                invalid;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, invalid
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, invalid
    );
endinterface

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder: one decimal_adder is reused for every digit,
// LSB digit first, with the decimal carry held in a register between cycles.
module decimal_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [4:0] raw;

    // Raw binary sums above 9 are corrected by +6 to skip the unused codes.
    always_comb begin
        raw  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        cout = (raw > 5'd9);
        s    = cout ? (raw[3:0] + 4'd6) : raw[3:0];
    end
endmodule

module bcd_serial_adder #(
    parameter int NDIG = 4
) (
    input  logic                clk,
    input  logic                rst,
    bcd_serial_adder_if.slave   bus
);
    localparam int W  = 4 * NDIG;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        FIN
    } state_t;

    state_t          state_reg;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic            carry_reg;
    logic [IW-1:0]   idx_reg;

    logic [2*NDIG-1:0] nibble_bad;
    logic              any_bad;
    logic [3:0]        dig_a;
    logic [3:0]        dig_b;
    logic [3:0]        dig_s;
    logic              dig_c;

    // Operand validity is judged on the live inputs at the moment start is taken.
    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_chk
            assign nibble_bad[2*gi]   = (bus.a[4*gi +: 4] > 4'd9);
            assign nibble_bad[2*gi+1] = (bus.b[4*gi +: 4] > 4'd9);
        end
    endgenerate

    assign any_bad = |nibble_bad;
    assign dig_a   = a_reg[{idx_reg, 2'b00} +: 4];
    assign dig_b   = b_reg[{idx_reg, 2'b00} +: 4];

    decimal_adder u_digit (
        .a    (dig_a),
        .b    (dig_b),
        .cin  (carry_reg),
        .s    (dig_s),
        .cout (dig_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            carry_reg   <= 1'b0;
            idx_reg     <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.sum     <= '0;
            bus.cout    <= 1'b0;
            bus.invalid <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        a_reg       <= bus.a;
                        b_reg       <= bus.b;
                        carry_reg   <= bus.cin;
                        idx_reg     <= '0;
                        bus.sum     <= '0;
                        bus.cout    <= 1'b0;
                        bus.invalid <= any_bad;
                        if (any_bad) begin
                            state_reg <= FIN;
                            bus.busy  <= 1'b0;
                        end else begin
                            state_reg <= ADD;
                            bus.busy  <= 1'b1;
                        end
                    end
                end
                ADD: begin
                    bus.sum[{idx_reg, 2'b00} +: 4] <= dig_s;
                    carry_reg <= dig_c;
                    // The index parks on the top digit rather than wrapping.
                    if (idx_reg == IW'(NDIG - 1)) begin
                        state_reg <= FIN;
                        bus.busy  <= 1'b0;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                FIN: begin
                    bus.done  <= 1'b1;
                    bus.cout  <= carry_reg & ~bus.invalid;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    bus.busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench: a decimal-arithmetic reference model predicts timing and
// results of every accepted request; directed cases pin the model with literals.
module tb_bcd_serial_adder;
    localparam int NDIG = 4;
    localparam int W    = 4 * NDIG;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bcd_serial_adder_if #(.NDIG(NDIG)) bus ();

    bcd_serial_adder #(.NDIG(NDIG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Decimal reference: decode both operands to integers, add, re-encode.
    function automatic void ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                                    output logic [W-1:0] s, output logic co, output logic inv);
        int va, vb, tot, lim;
        logic [3:0] da, db;
        va = 0; vb = 0; inv = 1'b0; lim = 1;
        for (int i = NDIG - 1; i >= 0; i--) begin
            da = a[4*i +: 4];
            db = b[4*i +: 4];
            if (da > 4'd9 || db > 4'd9) inv = 1'b1;
            va = va * 10 + int'(da);
            vb = vb * 10 + int'(db);
            lim = lim * 10;
        end
        s  = '0;
        co = 1'b0;
        if (!inv) begin
            tot = va + vb + int'(c);
            co  = (tot >= lim);
            tot = tot % lim;
            for (int i = 0; i < NDIG; i++) begin
                s[4*i +: 4] = 4'(tot % 10);
                tot = tot / 10;
            end
        end
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < NDIG; i++) begin
            if ($urandom_range(0, 19) == 0) r[4*i +: 4] = 4'($urandom_range(10, 15));
            else                            r[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        return r;
    endfunction

    // Model state: edge counter and the timing windows of the latest accepted request.
    int           cyc       = 0;
    int           acc_edge  = -10;
    int           busy_to   = -11;
    int           done_edge = -1;
    int           free_edge = 0;
    logic [W-1:0] m_sum     = '0;
    logic         m_cout    = 1'b0;
    logic         m_inv     = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_edge  = -10;
            busy_to   = -11;
            done_edge = -1;
            free_edge = 0;
            m_sum     = '0;
            m_cout    = 1'b0;
            m_inv     = 1'b0;
        end else begin
            cyc++;
            if (bus.start && cyc >= free_edge) begin
                ref_add(bus.a, bus.b, bus.cin, m_sum, m_cout, m_inv);
                acc_edge = cyc;
                if (m_inv) begin
                    busy_to   = cyc - 1;
                    done_edge = cyc + 1;
                    free_edge = cyc + 2;
                end else begin
                    busy_to   = cyc + NDIG - 1;
                    done_edge = cyc + NDIG + 1;
                    free_edge = cyc + NDIG + 2;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic exp_done, exp_busy, in_flight;
        exp_done  = (cyc == done_edge);
        exp_busy  = (cyc >= acc_edge) && (cyc <= busy_to);
        in_flight = (cyc >= acc_edge) && (cyc < done_edge);
        check("done", 32'(bus.done), 32'(exp_done));
        check("busy", 32'(bus.busy), 32'(exp_busy));
        if (!in_flight) begin
            check("sum",     32'(bus.sum),     32'(m_sum));
            check("cout",    32'(bus.cout),    32'(m_cout));
            check("invalid", 32'(bus.invalid), 32'(m_inv));
        end
        if (exp_done)
            $display("[TB] op done @%0d: sum=%h cout=%0d invalid=%0d (model sum=%h cout=%0d invalid=%0d)",
                     cyc, bus.sum, bus.cout, bus.invalid, m_sum, m_cout, m_inv);
    end

    // Issues one request and waits (bounded) for its done pulse.
    task automatic run_op(input string name, input bit at_negedge,
                          input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input logic [W-1:0] exp_sum, input logic exp_cout, input logic exp_inv,
                          input int exp_lat, input int exp_busy);
        int lat, busy_cnt;
        bit seen;
        if (!at_negedge) @(negedge clk);
        bus.a = a; bus.b = b; bus.cin = c; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0; busy_cnt = 0; seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        check({name, "_timeout"}, 32'(seen), 32'd1);
        check({name, "_sum"},     32'(bus.sum), 32'(exp_sum));
        check({name, "_cout"},    32'(bus.cout), 32'(exp_cout));
        check({name, "_invalid"}, 32'(bus.invalid), 32'(exp_inv));
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_busycnt"}, 32'(busy_cnt), 32'(exp_busy));
    endtask

    initial begin
        logic [W-1:0] ps;
        logic         pc, pi;
        int           dones, first_done, second_done;
        logic [W-1:0] cap_sum;
        logic         cap_cout;

        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;

        ref_add(16'h9999, 16'h9999, 1'b1, ps, pc, pi);
        check("pin_9999_sum", 32'(ps), 32'h9999);
        check("pin_9999_cout", 32'(pc), 32'd1);
        ref_add(16'h0999, 16'h0001, 1'b0, ps, pc, pi);
        check("pin_0999_sum", 32'(ps), 32'h1000);
        ref_add(16'h12A4, 16'h0001, 1'b0, ps, pc, pi);
        check("pin_12a4_inv", 32'(pi), 32'd1);

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);
        check("rst_invalid", 32'(bus.invalid), 32'd0);
        rst = 1'b0;

        run_op("ripple1000", 1'b0, 16'h0999, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, NDIG + 1, NDIG);
        run_op("max9999",    1'b0, 16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0, NDIG + 1, NDIG);
        run_op("invalid",    1'b0, 16'h12A4, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 1, 0);

        // A second start while busy must be dropped, not queued.
        @(negedge clk);
        bus.a = 16'h0005; bus.b = 16'h0005; bus.cin = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.a = 16'h1111; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        dones = 0; cap_sum = '0; cap_cout = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (bus.done) begin
                dones++;
                cap_sum  = bus.sum;
                cap_cout = bus.cout;
            end
            @(negedge clk);
        end
        check("ignore_dones", 32'(dones), 32'd1);
        check("ignore_sum", 32'(cap_sum), 32'h0010);
        check("ignore_cout", 32'(cap_cout), 32'd0);

        // Asynchronous reset in the second ADD cycle aborts without a done pulse.
        bus.a = 16'h4321; bus.b = 16'h1234; bus.cin = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        check("arst_sum", 32'(bus.sum), 32'd0);
        check("arst_cout", 32'(bus.cout), 32'd0);
        check("arst_invalid", 32'(bus.invalid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("arst_nodone", 32'(dones), 32'd0);
        run_op("after_rst", 1'b0, 16'h4321, 16'h1234, 1'b0, 16'h5555, 1'b0, 1'b0, NDIG + 1, NDIG);

        // Restart in the done cycle itself.
        run_op("b2b_first",  1'b0, 16'h8000, 16'h2001, 1'b0, 16'h0001, 1'b1, 1'b0, NDIG + 1, NDIG);
        run_op("b2b_second", 1'b1, 16'h0450, 16'h0550, 1'b1, 16'h1001, 1'b0, 1'b0, NDIG + 1, NDIG);

        // Start held high: one operation every NDIG+2 cycles.
        @(negedge clk);
        bus.a = 16'h1234; bus.b = 16'h4321; bus.cin = 1'b1; bus.start = 1'b1;
        dones = 0; first_done = -1; second_done = -1;
        for (int i = 0; i < 3 * (NDIG + 2); i++) begin
            @(negedge clk);
            if (bus.done) begin
                dones++;
                if (first_done < 0) first_done = i;
                else if (second_done < 0) second_done = i;
                check("held_sum", 32'(bus.sum), 32'h5556);
            end
        end
        bus.start = 1'b0;
        check("held_dones", 32'(dones), 32'd3);
        check("held_period", 32'(second_done - first_done), 32'(NDIG + 2));

        // Random traffic against the reference model.
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            bus.a     = rand_bcd();
            bus.b     = rand_bcd();
            bus.cin   = 1'($urandom_range(0, 1));
            bus.start = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        bus.start = 1'b0;
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
